// File: rtl/y86_fetch_seq.sv
// Multi-cycle Y86-64 fetch: reads instruction bytes one per handshake, decodes them, presents over valid/ready.
// Optional FETCH_PERF_CNT_EN adds perf_instr_o / perf_wait_o counters.
module y86_fetch_seq #(
    parameter int unsigned IMEM_DEPTH = 1024,
    parameter logic [63:0] RESET_PC   = 64'd0
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        run_i,
    output logic        mem_req_o,
    output logic [63:0] mem_addr_o,
    input  logic        mem_ack_i,
    input  logic [7:0]  mem_rdata_i,
    output logic        instr_valid_o,
    input  logic        instr_ready_i,
    input  logic        redirect_valid_i,
    input  logic [63:0] redirect_pc_i,
    output logic [63:0] pc_o,
    output logic [3:0]  icode_o,
    output logic [3:0]  ifunc_o,
    output logic [3:0]  rA_o,
    output logic [3:0]  rB_o,
    output logic [63:0] valC_o,
    output logic [63:0] valP_o,
    output logic [2:0]  stat_o,
    output logic        busy_o
`ifdef FETCH_PERF_CNT_EN
    ,
    output logic [31:0] perf_instr_o,
    output logic [31:0] perf_wait_o
`endif
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_DONE, S_HALT} state_t;

    localparam logic [2:0] STAT_AOK = 3'd1;
    localparam logic [2:0] STAT_HLT = 3'd2;
    localparam logic [2:0] STAT_ADR = 3'd3;
    localparam logic [2:0] STAT_INS = 3'd4;

    function automatic logic addr_bad(input logic [63:0] base, input logic [3:0] off);
        logic [64:0] sum;
        sum = {1'b0, base} + {61'd0, off};
        return sum > 65'(IMEM_DEPTH - 1);
    endfunction

    function automatic logic [3:0] instr_len(input logic [3:0] icode);
        case (icode)
            4'h2, 4'h6, 4'hA, 4'hB: return 4'd2;
            4'h7, 4'h8:             return 4'd9;
            4'h3, 4'h4, 4'h5:       return 4'd10;
            default:                return 4'd1;
        endcase
    endfunction

    function automatic logic has_reg(input logic [3:0] icode);
        case (icode)
            4'h2, 4'h3, 4'h4, 4'h5, 4'h6, 4'hA, 4'hB: return 1'b1;
            default:                                 return 1'b0;
        endcase
    endfunction

    state_t      state_q;
    logic [63:0] pc_q;
    logic [3:0]  count_q;
    logic [3:0]  len_q;
    logic        mem_req_q;
    logic [63:0] mem_addr_q;
    logic [3:0]  icode_q, ifunc_q, ra_q, rb_q;
    logic [63:0] valc_q;
    logic [2:0]  stat_q;

    logic [3:0]  cnt_inc;
    logic [3:0]  byte_icode;
    logic [3:0]  byte_len;
    logic [2:0]  valc_idx;
    logic [63:0] next_addr;
    logic        next_bad;
    logic [63:0] valp;
    logic [63:0] next_pc;
    logic        next_pc_bad;

    assign cnt_inc     = count_q + 4'd1;
    assign byte_icode  = mem_rdata_i[7:4];
    assign byte_len    = instr_len(byte_icode);
    assign valc_idx    = 3'(count_q - (has_reg(icode_q) ? 4'd2 : 4'd1));
    assign next_addr   = pc_q + {60'd0, cnt_inc};
    assign next_bad    = addr_bad(pc_q, cnt_inc);
    assign valp        = pc_q + {60'd0, count_q};
    assign next_pc     = redirect_valid_i ? redirect_pc_i : valp;
    assign next_pc_bad = addr_bad(next_pc, 4'd0);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            pc_q       <= RESET_PC;
            count_q    <= 4'd0;
            len_q      <= 4'd0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= 64'd0;
            icode_q    <= 4'h0;
            ifunc_q    <= 4'h0;
            ra_q       <= 4'hF;
            rb_q       <= 4'hF;
            valc_q     <= 64'd0;
            stat_q     <= STAT_AOK;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run_i) begin
                        if (addr_bad(pc_q, 4'd0)) begin
                            stat_q  <= STAT_ADR;
                            state_q <= S_DONE;
                        end else begin
                            state_q    <= S_REQ;
                            mem_req_q  <= 1'b1;
                            mem_addr_q <= pc_q;
                        end
                    end
                end
                S_REQ: begin
                    if (mem_ack_i) begin
                        count_q <= cnt_inc;
                        if (count_q == 4'd0) begin
                            icode_q <= byte_icode;
                            ifunc_q <= mem_rdata_i[3:0];
                            ra_q    <= 4'hF;
                            rb_q    <= 4'hF;
                            valc_q  <= 64'd0;
                            len_q   <= byte_len;
                        end else if (has_reg(icode_q) && count_q == 4'd1) begin
                            ra_q <= mem_rdata_i[7:4];
                            rb_q <= mem_rdata_i[3:0];
                        end else begin
                            valc_q[{valc_idx, 3'b000} +: 8] <= mem_rdata_i;
                        end
                        // Length is known from the byte just arriving when count is 0
                        if (count_q == 4'd0 && byte_icode >= 4'hC) begin
                            stat_q    <= STAT_INS;
                            state_q   <= S_DONE;
                            mem_req_q <= 1'b0;
                        end else if ((count_q == 4'd0) ? (byte_len == 4'd1) : (cnt_inc == len_q)) begin
                            if (count_q == 4'd0 && byte_icode == 4'h0)
                                stat_q <= STAT_HLT;
                            state_q   <= S_DONE;
                            mem_req_q <= 1'b0;
                        end else if (next_bad) begin
                            stat_q    <= STAT_ADR;
                            state_q   <= S_DONE;
                            mem_req_q <= 1'b0;
                        end else begin
                            mem_addr_q <= next_addr;
                        end
                    end
                end
                S_DONE: begin
                    if (instr_ready_i) begin
                        // PC is left untouched on the way to HALT so pc_o keeps showing the last instruction
                        if (stat_q != STAT_AOK) begin
                            state_q <= S_HALT;
                        end else begin
                            pc_q    <= next_pc;
                            count_q <= 4'd0;
                            len_q   <= 4'd0;
                            icode_q <= 4'h0;
                            ifunc_q <= 4'h0;
                            ra_q    <= 4'hF;
                            rb_q    <= 4'hF;
                            valc_q  <= 64'd0;
                            if (next_pc_bad) begin
                                stat_q <= STAT_ADR;
                            end else begin
                                state_q    <= S_REQ;
                                mem_req_q  <= 1'b1;
                                mem_addr_q <= next_pc;
                            end
                        end
                    end
                end
                S_HALT:  state_q <= S_HALT;
                default: state_q <= S_IDLE;
            endcase
        end
    end

`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_instr_q;
    logic [31:0] perf_wait_q;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            perf_instr_q <= 32'd0;
            perf_wait_q  <= 32'd0;
        end else begin
            if (state_q == S_DONE && instr_ready_i)
                perf_instr_q <= perf_instr_q + 32'd1;
            if (state_q == S_REQ && !mem_ack_i)
                perf_wait_q <= perf_wait_q + 32'd1;
        end
    end

    assign perf_instr_o = perf_instr_q;
    assign perf_wait_o  = perf_wait_q;
`endif

    assign mem_req_o     = mem_req_q;
    assign mem_addr_o    = mem_addr_q;
    assign instr_valid_o = (state_q == S_DONE);
    assign busy_o        = (state_q == S_REQ) || (state_q == S_DONE);
    assign pc_o          = pc_q;
    assign icode_o       = icode_q;
    assign ifunc_o       = ifunc_q;
    assign rA_o          = ra_q;
    assign rB_o          = rb_q;
    assign valC_o        = valc_q;
    assign valP_o        = valp;
    assign stat_o        = stat_q;

endmodule

// File: tb/tb_y86_fetch_seq.sv
// Directed bench for y86_fetch_seq: table of single-instruction decodes plus multi-cycle corner sequences.
module tb_y86_fetch_seq;

    logic        clk = 1'b0;
    logic        rst_i = 1'b0;
    logic        run_i = 1'b0;
    logic        mem_req_o;
    logic [63:0] mem_addr_o;
    logic        mem_ack_i;
    logic [7:0]  mem_rdata_i;
    logic        instr_valid_o;
    logic        instr_ready_i = 1'b0;
    logic        redirect_valid_i = 1'b0;
    logic [63:0] redirect_pc_i = 64'd0;
    logic [63:0] pc_o;
    logic [3:0]  icode_o, ifunc_o, rA_o, rB_o;
    logic [63:0] valC_o, valP_o;
    logic [2:0]  stat_o;
    logic        busy_o;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0] perf_instr_o, perf_wait_o;
`endif

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    y86_fetch_seq dut (
        .clk_i(clk), .rst_i(rst_i), .run_i(run_i),
        .mem_req_o(mem_req_o), .mem_addr_o(mem_addr_o),
        .mem_ack_i(mem_ack_i), .mem_rdata_i(mem_rdata_i),
        .instr_valid_o(instr_valid_o), .instr_ready_i(instr_ready_i),
        .redirect_valid_i(redirect_valid_i), .redirect_pc_i(redirect_pc_i),
        .pc_o(pc_o), .icode_o(icode_o), .ifunc_o(ifunc_o),
        .rA_o(rA_o), .rB_o(rB_o), .valC_o(valC_o), .valP_o(valP_o),
        .stat_o(stat_o), .busy_o(busy_o)
`ifdef FETCH_PERF_CNT_EN
        , .perf_instr_o(perf_instr_o), .perf_wait_o(perf_wait_o)
`endif
    );

    // Byte memory with a programmable number of wait cycles before each ack
    logic [7:0] mem [0:1023];
    int wait_cfg = 0;
    int wait_cnt = 0;
    assign mem_ack_i   = mem_req_o && (wait_cnt >= wait_cfg);
    assign mem_rdata_i = (mem_addr_o < 64'd1024) ? mem[mem_addr_o[9:0]] : 8'h00;
    always @(posedge clk) begin
        if (mem_req_o && !mem_ack_i) wait_cnt <= wait_cnt + 1;
        else                         wait_cnt <= 0;
    end

    typedef struct {
        logic [0:9][7:0] b;
        logic [3:0]      icode, ifunc, ra, rb;
        logic [63:0]     valc, valp;
        logic [2:0]      stat;
        int              cyc;
    } vec_t;
    vec_t vecs [11];

    int        acks_seen;
    int        addr_errs;
    logic [63:0] max_addr;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic do_reset();
        run_i = 1'b0; instr_ready_i = 1'b0; redirect_valid_i = 1'b0; wait_cfg = 0;
        rst_i = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_i = 1'b0;
    endtask

    task automatic clear_mem();
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    endtask

    task automatic load(input int base, input logic [0:9][7:0] b, input int n);
        for (int i = 0; i < n; i++) mem[base + i] = b[i];
    endtask

    task automatic start_run();
        @(negedge clk) run_i = 1'b1;
        @(posedge clk); #1;
        run_i = 1'b0;
    endtask

    // Called #1 after an edge; returns edges elapsed until instr_valid_o, tracking addresses
    task automatic wait_valid(input logic [63:0] base, output int cyc);
        cyc = 0; acks_seen = 0; addr_errs = 0; max_addr = 64'd0;
        while (!instr_valid_o) begin
            if (mem_req_o) begin
                if (mem_addr_o !== base + 64'(acks_seen)) addr_errs++;
                if (mem_addr_o > max_addr) max_addr = mem_addr_o;
                if (mem_ack_i) acks_seen++;
            end
            @(posedge clk); #1;
            cyc++;
            if (cyc > 200) begin
                n_checks++; n_fail++;
                $display("FAIL timeout: no instr_valid_o after %0d cycles", cyc);
                return;
            end
        end
    endtask

    // Hold ready for one edge while in DONE; returns #1 after the accepting edge
    task automatic accept();
        instr_ready_i = 1'b1;
        @(posedge clk); #1;
        instr_ready_i = 1'b0;
    endtask

    logic [0:9][7:0] jmp_b;
    logic [0:9][7:0] irm_b;
    logic [63:0] seen_valp [2];
    logic [2:0]  seen_stat [2];

    initial begin
        int cyc;
        int nseen;

        vecs[0]  = '{b: {8'h30,8'hf8,8'h08,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, icode: 4'h3, ifunc: 4'h0, ra: 4'hF, rb: 4'h8, valc: 64'h8, valp: 64'd10, stat: 3'd1, cyc: 10};
        vecs[1]  = '{b: {8'h10,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, icode: 4'h1, ifunc: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0, valp: 64'd1, stat: 3'd1, cyc: 1};
        vecs[2]  = '{b: {8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, icode: 4'h0, ifunc: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0, valp: 64'd1, stat: 3'd2, cyc: 1};
        vecs[3]  = '{b: {8'h60,8'h23,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, icode: 4'h6, ifunc: 4'h0, ra: 4'h2, rb: 4'h3, valc: 64'h0, valp: 64'd2, stat: 3'd1, cyc: 2};
        vecs[4]  = '{b: {8'h70,8'h00,8'h01,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, icode: 4'h7, ifunc: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h100, valp: 64'd9, stat: 3'd1, cyc: 9};
        vecs[5]  = '{b: {8'h80,8'h88,8'h77,8'h66,8'h55,8'h44,8'h33,8'h22,8'h11,8'h00}, icode: 4'h8, ifunc: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h1122334455667788, valp: 64'd9, stat: 3'd1, cyc: 9};
        vecs[6]  = '{b: {8'h40,8'h15,8'hef,8'hcd,8'hab,8'h89,8'h67,8'h45,8'h23,8'h01}, icode: 4'h4, ifunc: 4'h0, ra: 4'h1, rb: 4'h5, valc: 64'h0123456789abcdef, valp: 64'd10, stat: 3'd1, cyc: 10};
        vecs[7]  = '{b: {8'hc0,8'h11,8'h22,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, icode: 4'hC, ifunc: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0, valp: 64'd1, stat: 3'd4, cyc: 1};
        vecs[8]  = '{b: {8'h21,8'h34,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, icode: 4'h2, ifunc: 4'h1, ra: 4'h3, rb: 4'h4, valc: 64'h0, valp: 64'd2, stat: 3'd1, cyc: 2};
        vecs[9]  = '{b: {8'h90,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, icode: 4'h9, ifunc: 4'h0, ra: 4'hF, rb: 4'hF, valc: 64'h0, valp: 64'd1, stat: 3'd1, cyc: 1};
        vecs[10] = '{b: {8'ha0,8'h4f,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00}, icode: 4'hA, ifunc: 4'h0, ra: 4'h4, rb: 4'hF, valc: 64'h0, valp: 64'd2, stat: 3'd1, cyc: 2};
        jmp_b = {8'h70,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};
        irm_b = {8'h30,8'hf8,8'h08,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00,8'h00};

        // Reset state
        #1 rst_i = 1'b1;
        @(posedge clk); #1;
        check("rst_mem_req", 64'(mem_req_o), 64'd0);
        check("rst_valid", 64'(instr_valid_o), 64'd0);
        check("rst_busy", 64'(busy_o), 64'd0);
        check("rst_stat", 64'(stat_o), 64'd1);
        check("rst_ra_rb", 64'({rA_o, rB_o}), 64'hFF);
        check("rst_pc_valp_valc", pc_o | valP_o | valC_o, 64'd0);
        check("rst_icode_ifunc", 64'({icode_o, ifunc_o}), 64'd0);

        // Table: one instruction at address 0, zero-wait memory
        for (int v = 0; v < 11; v++) begin
            do_reset();
            clear_mem();
            load(0, vecs[v].b, 10);
            start_run();
            wait_valid(64'd0, cyc);
            $display("vec %0d: icode %h ifunc %h rA %h rB %h valC %h valP %0d stat %0d after %0d cycles",
                     v, icode_o, ifunc_o, rA_o, rB_o, valC_o, valP_o, stat_o, cyc);
            check($sformatf("v%0d_cycles", v), 64'(cyc), 64'(vecs[v].cyc));
            check($sformatf("v%0d_icode", v), 64'(icode_o), 64'(vecs[v].icode));
            check($sformatf("v%0d_ifunc", v), 64'(ifunc_o), 64'(vecs[v].ifunc));
            check($sformatf("v%0d_rA", v), 64'(rA_o), 64'(vecs[v].ra));
            check($sformatf("v%0d_rB", v), 64'(rB_o), 64'(vecs[v].rb));
            check($sformatf("v%0d_valC", v), valC_o, vecs[v].valc);
            check($sformatf("v%0d_valP", v), valP_o, vecs[v].valp);
            check($sformatf("v%0d_stat", v), 64'(stat_o), 64'(vecs[v].stat));
            check($sformatf("v%0d_pc", v), pc_o, 64'd0);
            check($sformatf("v%0d_addr_seq", v), 64'(addr_errs), 64'd0);
            check($sformatf("v%0d_busy", v), 64'(busy_o), 64'd1);
            accept();
        end

        // nop then halt with ready held high
        do_reset();
        clear_mem();
        mem[0] = 8'h10; mem[1] = 8'h00;
        instr_ready_i = 1'b1;
        start_run();
        nseen = 0;
        for (int c = 0; c < 20; c++) begin
            if (instr_valid_o) begin
                if (nseen < 2) begin seen_valp[nseen] = valP_o; seen_stat[nseen] = stat_o; end
                $display("stream instr %0d: valP %0d stat %0d", nseen, valP_o, stat_o);
                nseen++;
            end
            @(posedge clk); #1;
        end
        instr_ready_i = 1'b0;
        check("seq_count", 64'(nseen), 64'd2);
        check("seq_valp0", seen_valp[0], 64'd1);
        check("seq_stat0", 64'(seen_stat[0]), 64'd1);
        check("seq_valp1", seen_valp[1], 64'd2);
        check("seq_stat1", 64'(seen_stat[1]), 64'd2);
        check("halt_mem_req", 64'(mem_req_o), 64'd0);
        check("halt_valid", 64'(instr_valid_o), 64'd0);
        check("halt_pc_hold", pc_o, 64'd1);

        // OPq with three wait cycles per byte
        do_reset();
        clear_mem();
        mem[0] = 8'h60; mem[1] = 8'h23;
        wait_cfg = 3;
        start_run();
        wait_valid(64'd0, cyc);
        $display("opq wait: rA %h rB %h valP %0d after %0d cycles", rA_o, rB_o, valP_o, cyc);
        check("wait_cycles", 64'(cyc), 64'd8);
        check("wait_addr_stable", 64'(addr_errs), 64'd0);
        check("wait_ra_rb", 64'({rA_o, rB_o}), 64'h23);
        check("wait_valp", valP_o, 64'd2);
        accept();
`ifdef FETCH_PERF_CNT_EN
        check("perf_instr", 64'(perf_instr_o), 64'd1);
        check("perf_wait", 64'(perf_wait_o), 64'd6);
`endif
        wait_cfg = 0;

        // jmp redirected to 0x40 which holds an invalid opcode
        do_reset();
        clear_mem();
        load(0, jmp_b, 9);
        mem[8'h40] = 8'hC0;
        start_run();
        wait_valid(64'd0, cyc);
        redirect_valid_i = 1'b1; redirect_pc_i = 64'h40;
        accept();
        redirect_valid_i = 1'b0; redirect_pc_i = 64'hDEAD;
        $display("redirect: mem_req %0d addr %h", mem_req_o, mem_addr_o);
        check("redir_req", 64'(mem_req_o), 64'd1);
        check("redir_addr", mem_addr_o, 64'h40);
        wait_valid(64'h40, cyc);
        check("ins_stat", 64'(stat_o), 64'd4);
        check("ins_valp", valP_o, 64'h41);
        check("ins_pc", pc_o, 64'h40);
        check("ins_icode", 64'(icode_o), 64'hC);
        accept();
        repeat (3) @(posedge clk);
        #1;
        check("ins_halt_valid", 64'(instr_valid_o), 64'd0);
        check("ins_halt_req", 64'(mem_req_o | busy_o), 64'd0);
        check("ins_halt_stat", 64'(stat_o), 64'd4);

        // irmovq straddling the end of memory at 1020
        do_reset();
        clear_mem();
        load(0, jmp_b, 9);
        load(1020, irm_b, 4);
        start_run();
        wait_valid(64'd0, cyc);
        redirect_valid_i = 1'b1; redirect_pc_i = 64'd1020;
        accept();
        redirect_valid_i = 1'b0;
        wait_valid(64'd1020, cyc);
        $display("adr: stat %0d pc %0d valP %0d acks %0d max addr %0d", stat_o, pc_o, valP_o, acks_seen, max_addr);
        check("adr_stat", 64'(stat_o), 64'd3);
        check("adr_acks", 64'(acks_seen), 64'd4);
        check("adr_max_addr", max_addr, 64'd1023);
        check("adr_addr_seq", 64'(addr_errs), 64'd0);
        check("adr_pc", pc_o, 64'd1020);
        check("adr_valp", valP_o, 64'd1024);

        // Reset in the middle of a fetch
        do_reset();
        clear_mem();
        load(0, jmp_b, 9);
        load(16'h100, irm_b, 10);
        start_run();
        wait_valid(64'd0, cyc);
        redirect_valid_i = 1'b1; redirect_pc_i = 64'h100;
        accept();
        redirect_valid_i = 1'b0;
        @(posedge clk); #1;
        check("mid_pc", pc_o, 64'h100);
        check("mid_req", 64'(mem_req_o), 64'd1);
        #2 rst_i = 1'b1;
        #1;
        $display("async reset: mem_req %0d pc %h", mem_req_o, pc_o);
        check("arst_req", 64'(mem_req_o), 64'd0);
        check("arst_pc", pc_o, 64'd0);
        check("arst_busy", 64'(busy_o), 64'd0);
        check("arst_stat", 64'(stat_o), 64'd1);
        @(negedge clk) rst_i = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
